// File: rtl/imem_fetch_pkg.sv
// imem_fetch_pkg: shared types and constants for the instruction-fetch block.
//   fetch_state_t : fetch sequencer states (IDLE, RUN, END)
//   fetch_entry_t : one prefetch entry {pc, instr} at the default 32-bit width
//   PC_STEP       : byte increment between sequential instructions
package imem_fetch_pkg;

    localparam int IMEM_N = 32;

    localparam logic [63:0] PC_STEP = 64'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        END  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [63:0]       pc;
        logic [IMEM_N-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with push, pop and flush.
//   clk, reset (async, active-low)
//   push/din    : write an entry
//   pop/dout    : dout shows the head entry; pop removes it
//   flush       : empties the FIFO, overriding push and pop
//   full/empty/count : occupancy status
// Pointers are $clog2(DEPTH) bits so they wrap modulo DEPTH (DEPTH is a power
// of two); count carries one extra bit so it can hold DEPTH itself.
module fetch_fifo #(
    parameter int W     = 96,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset: empty/valid gating downstream hides stale data.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: instruction-fetch sequencer between the instruction ROM and
// decode. Owns the fetch PC, drives the ROM word address and buffers fetched
// {pc, instr} pairs in a prefetch FIFO; redirects flush and refetch.
//   clk, reset (async, active-low)
//   fetch_en                      : allow fetching to start/continue
//   imem_addr / imem_q            : ROM word address (pc[AW+1:2]) / data
//   redirect_valid / redirect_pc  : branch redirect strobe and byte target
//   instr_valid / instr_ready     : head-entry handshake; a transfer happens
//                                   on a rising edge where both are 1, and
//                                   instr/instr_pc hold while valid & !ready
//   instr / instr_pc              : head instruction and its byte PC (0 when
//                                   instr_valid is 0)
//   fetch_done                    : fetch PC has run past the ROM end
//   dbg_state / dbg_count         : FSM state and FIFO occupancy
// Optional feature: IMEM_FETCH_BYPASS_EN presents the ROM word directly when
// the FIFO is empty so it can be consumed with zero latency.
module imem_fetch_ctrl
    import imem_fetch_pkg::*;
#(
    parameter int N     = 32,
    parameter int AW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   fetch_en,
    output logic [AW-1:0]          imem_addr,
    input  logic [N-1:0]           imem_q,
    input  logic                   redirect_valid,
    input  logic [63:0]            redirect_pc,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [N-1:0]           instr,
    output logic [63:0]            instr_pc,
    output logic                   fetch_done,
    output logic [1:0]             dbg_state,
    output logic [$clog2(DEPTH):0] dbg_count
);

    localparam int EW = 64 + N;

    fetch_state_t state, state_nx;
    logic [63:0]  pc, pc_nx;
    logic [63:0]  target_pc;

    logic          push, pop, flush, full, empty;
    logic [EW-1:0] din, dout;

    logic fetch_ok, bypass, consume, adv, last_word;

    fetch_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (din),
        .dout  (dout),
        .full  (full),
        .empty (empty),
        .count (dbg_count)
    );

    assign imem_addr = pc[AW+1:2];
    assign last_word = (pc[AW+1:2] == {AW{1'b1}});
    assign target_pc = redirect_pc & ~64'd3;
    assign din       = {pc, imem_q};
    assign flush     = redirect_valid;

    always_comb begin
        fetch_ok = (state == RUN) && fetch_en && !redirect_valid;
`ifdef IMEM_FETCH_BYPASS_EN
        bypass   = fetch_ok && empty;
        consume  = bypass && instr_ready;
`else
        bypass   = 1'b0;
        consume  = 1'b0;
`endif
        instr_valid = !empty || bypass;
        // A redirect cycle never pops, so the flushed head is not consumed.
        pop  = !redirect_valid && !empty && instr_ready;
        push = fetch_ok && !consume && (!full || pop);
        adv  = push || consume;

        instr    = '0;
        instr_pc = '0;
        if (bypass) begin
            instr    = imem_q;
            instr_pc = pc;
        end else if (!empty) begin
            instr    = dout[N-1:0];
            instr_pc = dout[EW-1:N];
        end
    end

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        case (state)
            IDLE:    if (fetch_en) state_nx = RUN;
            RUN:     if (adv && last_word) state_nx = END;
            END:     state_nx = END;
            default: state_nx = IDLE;
        endcase
        if (adv) pc_nx = pc + PC_STEP;
        if (redirect_valid) begin
            pc_nx = target_pc;
            if (redirect_pc[63:AW+2] != '0)
                state_nx = END;
            else if (state == IDLE && !fetch_en)
                state_nx = IDLE;
            else
                state_nx = RUN;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            pc    <= '0;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
        end
    end

    assign fetch_done = (state == END);
    assign dbg_state  = state;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
module tb_imem_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_en;
    logic [7:0]  imem_addr;
    logic [31:0] imem_q;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        fetch_done;
    logic [1:0]  dbg_state;
    logic [2:0]  dbg_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    imem_fetch_ctrl #(.N(32), .AW(8), .DEPTH(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .fetch_en       (fetch_en),
        .imem_addr      (imem_addr),
        .imem_q         (imem_q),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .fetch_done     (fetch_done),
        .dbg_state      (dbg_state),
        .dbg_count      (dbg_count)
    );

    // ROM contents: word 0 is 32'hf8000001, word a is 32'h1000_0000 | a.
    function automatic logic [31:0] rom(input logic [7:0] a);
        return (a == 8'd0) ? 32'hf8000001 : (32'h10000000 | {24'd0, a});
    endfunction

    assign imem_q = rom(imem_addr);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect(input logic [63:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        step();
        redirect_valid = 1'b0;
        redirect_pc    = '0;
    endtask

    initial begin
        reset          = 1'b0;
        fetch_en       = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        #1;
        check("rst_valid", 64'(instr_valid), 64'd0);
        check("rst_instr", 64'(instr), 64'd0);
        check("rst_pc", instr_pc, 64'd0);
        check("rst_addr", 64'(imem_addr), 64'd0);
        check("rst_done", 64'(fetch_done), 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);
        step();
        step();
        reset = 1'b1;

        // First fetch: IDLE->RUN on edge 1, push word 0 on edge 2.
        fetch_en    = 1'b1;
        instr_ready = 1'b1;
        step();
        check("e1_valid", 64'(instr_valid), 64'd0);
        check("e1_state", 64'(dbg_state), 64'd1);
        step();
        check("e2_valid", 64'(instr_valid), 64'd1);
        check("e2_instr", 64'(instr), 64'hf8000001);
        check("e2_pc", instr_pc, 64'd0);
        step();
        check("e3_pc", instr_pc, 64'd4);
        check("e3_instr", 64'(instr), 64'h10000001);

        // Stall: refill from PC 0 with ready low for 10 cycles.
        instr_ready = 1'b0;
        redirect(64'd0);
        check("stall_flush_valid", 64'(instr_valid), 64'd0);
        for (int i = 0; i < 10; i++) step();
        check("stall_count", 64'(dbg_count), 64'd4);
        check("stall_addr", 64'(imem_addr), 64'd4);
        check("stall_head_pc", instr_pc, 64'd0);
        check("stall_head_instr", 64'(instr), 64'hf8000001);
        instr_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            check($sformatf("drain_pc_%0d", i), instr_pc, 64'(4 * i));
            check($sformatf("drain_valid_%0d", i), 64'(instr_valid), 64'd1);
        end
        check("drain_instr_5", 64'(instr), 64'h10000005);

        // Redirect to 0x40 with 3 entries buffered.
        instr_ready = 1'b0;
        redirect(64'd0);
        for (int i = 0; i < 3; i++) step();
        check("three_count", 64'(dbg_count), 64'd3);
        redirect(64'h40);
        instr_ready = 1'b1;
        check("rd40_valid_drop", 64'(instr_valid), 64'd0);
        check("rd40_count", 64'(dbg_count), 64'd0);
        step();
        check("rd40_valid", 64'(instr_valid), 64'd1);
        check("rd40_pc", instr_pc, 64'h40);
        check("rd40_instr", 64'(instr), 64'h10000010);

        // Redirect to the last ROM word: one instruction, then END.
        redirect(64'h3fc);
        check("last_valid0", 64'(instr_valid), 64'd0);
        check("last_done0", 64'(fetch_done), 64'd0);
        step();
        check("last_valid", 64'(instr_valid), 64'd1);
        check("last_pc", instr_pc, 64'h3fc);
        check("last_instr", 64'(instr), 64'h100000ff);
        check("last_done", 64'(fetch_done), 64'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("end_valid_%0d", i), 64'(instr_valid), 64'd0);
        end
        check("end_done", 64'(fetch_done), 64'd1);
        check("end_state", 64'(dbg_state), 64'd2);

        // Redirect to 0 restarts from END.
        redirect(64'd0);
        check("restart_done", 64'(fetch_done), 64'd0);
        check("restart_valid0", 64'(instr_valid), 64'd0);
        step();
        check("restart_pc", instr_pc, 64'd0);
        check("restart_instr", 64'(instr), 64'hf8000001);

        // Redirect past the ROM end: straight to END, nothing delivered.
        redirect(64'h400);
        check("oob_done", 64'(fetch_done), 64'd1);
        check("oob_valid0", 64'(instr_valid), 64'd0);
        step();
        check("oob_valid1", 64'(instr_valid), 64'd0);

        // Misaligned redirect target: low bits forced to zero.
        redirect(64'h8b);
        check("mis_done", 64'(fetch_done), 64'd0);
        step();
        check("mis_pc", instr_pc, 64'h88);
        check("mis_instr", 64'(instr), 64'h10000022);

        // Reset with FIFO full: outputs return to zero immediately.
        instr_ready = 1'b0;
        redirect(64'd0);
        for (int i = 0; i < 5; i++) step();
        check("pre_rst_count", 64'(dbg_count), 64'd4);
        check("pre_rst_valid", 64'(instr_valid), 64'd1);
        reset = 1'b0;
        #1;
        check("mid_rst_valid", 64'(instr_valid), 64'd0);
        check("mid_rst_instr", 64'(instr), 64'd0);
        check("mid_rst_pc", instr_pc, 64'd0);
        check("mid_rst_addr", 64'(imem_addr), 64'd0);
        check("mid_rst_count", 64'(dbg_count), 64'd0);
        fetch_en = 1'b0;
        step();
        reset = 1'b1;
        instr_ready = 1'b1;
        step();
        step();
        check("idle_valid", 64'(instr_valid), 64'd0);
        check("idle_state", 64'(dbg_state), 64'd0);
        fetch_en = 1'b1;
        step();
        check("post_rst_valid0", 64'(instr_valid), 64'd0);
        step();
        check("post_rst_valid", 64'(instr_valid), 64'd1);
        check("post_rst_pc", instr_pc, 64'd0);
        check("post_rst_instr", 64'(instr), 64'hf8000001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Instruction-fetch sequencer between the 256-word instruction ROM (`imem`) and the decode stage. It owns the fetch PC, drives the ROM word address, and buffers fetched words with their PCs in a small prefetch FIFO. It hands instructions downstream over a valid/ready handshake and honours branch redirects by flushing and refetching.

## Interface
- `N`, 32, instruction width (matches `imem` `N`)
- `AW`, 8, ROM word-address width (ROM holds 2^AW words)
- `DEPTH`, 4, prefetch FIFO entries (power of two, ≥2)
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `fetch_en`  in  1  level; allows fetching to start/continue
- `imem_addr`  out  AW  ROM word address, = `pc[AW+1:2]`
- `imem_q`  in  N  ROM data (combinational, same cycle as `imem_addr`)
- `redirect_valid`  in  1  single-cycle branch/jump redirect strobe
- `redirect_pc`  in  64  byte target PC of the redirect
- `instr_valid`  out  1  head entry valid
- `instr_ready`  in  1  decode accepts the head entry
- `instr`  out  N  head instruction
- `instr_pc`  out  64  byte PC of head instruction
- `fetch_done`  out  1  fetch PC has run past the ROM end

## Operation
- States: IDLE, RUN, END.
- IDLE: no pushes; go to RUN when `fetch_en`=1.
- RUN: push `{pc, imem_q}` into FIFO when `fetch_en`=1 and FIFO not full, or full with a pop in the same cycle; then `pc <= pc+4`. `fetch_en`=0 pauses pushes; state stays RUN.
- A push from the last ROM word (`pc[AW+1:2]` = 2^AW−1) moves the FSM to END. No address wrap.
- END: no pushes; `fetch_done`=1; FIFO keeps draining normally.
- Pop: `instr_valid & instr_ready`.
- Redirect has top priority. The FIFO is flushed (count=0, no push, no pop this cycle) and `pc <= redirect_pc`. The next state is RUN if `redirect_pc[63:AW+2]`=0, else END. This applies from any state, including END and IDLE (IDLE→RUN only if `fetch_en`).
- Redirects with `redirect_pc[1:0]`≠0: the low bits are forced to 0.
- `instr`/`instr_pc` are held stable while `instr_valid`=1 and `instr_ready`=0.
- Occupancy counter is width $clog2(DEPTH)+1; pointers wrap modulo DEPTH.

## Timing
- Reset values: `pc`=0, state IDLE, FIFO empty, `instr_valid`=0, `instr`=0, `instr_pc`=0, `imem_addr`=0, `fetch_done`=0.
- `imem_addr` is a combinational function of the `pc` register only.
- Push-to-visible latency is 1 cycle: an entry pushed on edge k shows `instr_valid`=1 after edge k.
- In steady state, with `instr_ready`=1, throughput is 1 instruction/cycle.
- After a redirect on edge k, the first new instruction is pushed on edge k+1 and is valid after edge k+1.
- `instr_valid` drops to 0 on the cycle after a redirect edge.
- Reset asserted mid-operation immediately returns all state to its reset values; any in-flight entries are lost.

## Configuration
- `IMEM_FETCH_BYPASS_EN` defined: when the FIFO is empty, RUN, and `fetch_en`=1, `imem_q`/`pc` are presented combinationally with `instr_valid`=1.
  - If `instr_ready`=1, the word is consumed without a push. Latency is 0 and `pc` advances.
  - Otherwise it is pushed as normal.
- Not defined: no combinational path from `imem_q` to `instr`. Latency is always ≥1 cycle.

## Structure
- `imem_fetch_pkg`: state enum `fetch_state_t` {IDLE, RUN, END}; `fetch_entry_t` struct {pc[63:0], instr[N-1:0]}; constant `PC_STEP`=4.
- Sub-module `fetch_fifo`: parameterised sync FIFO with push/pop/flush, full/empty and count.
- `imem_fetch_ctrl` holds the FSM, PC and handshake logic.

## Test plan
- Reset, then `fetch_en`=1, `instr_ready`=1, ROM word0=32'hf8000001 → after edge 2, `instr`=32'hf8000001, `instr_pc`=0; next cycle `instr_pc`=4.
- `instr_ready`=0 for 10 cycles → exactly DEPTH=4 entries buffered, `imem_addr`=4 and stalled. Releasing ready then yields PCs 0,4,8,12,16 with no gap or duplicate.
- Redirect to 0x40 while FIFO holds 3 entries → next cycle `instr_valid`=0; the following cycle `instr_pc`=0x40, `instr`=ROM[16].
- Redirect to 0x3FC (last word), ready=1 → one instruction at PC 0x3FC, then `fetch_done`=1 and `instr_valid`=0 permanently. A redirect to 0 then restarts fetch at PC 0.
- Redirect to 0x400 → END immediately, no instruction delivered, `fetch_done`=1.
- Assert reset mid-stream with FIFO full → outputs immediately 0. After release, fetch restarts at PC 0 once `fetch_en`=1.
